text_screen: RTL and testbench

- Parametrised full-screen VGA title/message overlay: uniform background, a filled text box, and a string drawn from an internal 5x7 glyph ROM with integer pixel scaling.
- Two selectable messages ("START GAME", "GAME OVER "), frame-synchronous message switching, optional frame-counted blinking.
- Sits in the vga_if pixel chain in place of the fixed start/finish screens. Delays all timing signals to match its 2-cycle pixel pipeline.

---
 rtl/text_screen.sv | 185 ++++++++++++++++++
 tb/tb_text_screen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/text_screen.sv
// text_screen: full-screen VGA title/message overlay.
// Draws a uniform background, a filled box and one of two 10-character messages from a
// built-in 5x7 glyph ROM, scaled by 2**SCALE_LOG2. Timing signals are delayed by the same
// 2-cycle pipeline as the colour. Message select and blink phase change only on frame start.
// Ports:
//   clk, rst             pixel clock, asynchronous active-high reset
//   msg_sel              0 = "START GAME", 1 = "GAME OVER " (sampled at frame start)
//   blink_en             1 = text blinks every BLINK_FRAMES frames, 0 = always visible
//   vga_in_*             incoming pixel stream (rgb is ignored)
//   vga_out_*            same stream delayed 2 clk, rgb replaced by the overlay colour
module text_screen #(
    parameter int unsigned TEXT_X       = 275,
    parameter int unsigned TEXT_Y       = 333,
    parameter int unsigned SCALE_LOG2   = 2,
    parameter int unsigned NUM_CHARS    = 10,
    parameter int unsigned BOX_MARGIN   = 16,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [11:0] BG_COLOR     = 12'h0_f_0,
    parameter logic [11:0] BOX_COLOR    = 12'hf_f_0,
    parameter logic [11:0] TEXT_COLOR   = 12'h0_0_0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_sel,
    input  logic        blink_en,
    input  logic [10:0] vga_in_hcount,
    input  logic [10:0] vga_in_vcount,
    input  logic        vga_in_hsync,
    input  logic        vga_in_vsync,
    input  logic        vga_in_hblnk,
    input  logic        vga_in_vblnk,
    input  logic [11:0] vga_in_rgb,
    output logic [10:0] vga_out_hcount,
    output logic [10:0] vga_out_vcount,
    output logic        vga_out_hsync,
    output logic        vga_out_vsync,
    output logic        vga_out_hblnk,
    output logic        vga_out_vblnk,
    output logic [11:0] vga_out_rgb
);
    localparam int unsigned Scale = 1 << SCALE_LOG2;
    localparam int unsigned TextW = NUM_CHARS * 6 * Scale;
    localparam int unsigned TextH = 8 * Scale;
    localparam logic [10:0] TxLo  = 11'(TEXT_X);
    localparam logic [10:0] TxHi  = 11'(TEXT_X + TextW);
    localparam logic [10:0] TyLo  = 11'(TEXT_Y);
    localparam logic [10:0] TyHi  = 11'(TEXT_Y + TextH);
    localparam logic [10:0] BxLo  = 11'(TEXT_X - BOX_MARGIN);
    localparam logic [10:0] BxHi  = 11'(TEXT_X + TextW + BOX_MARGIN);
    localparam logic [10:0] ByLo  = 11'(TEXT_Y - BOX_MARGIN);
    localparam logic [10:0] ByHi  = 11'(TEXT_Y + TextH + BOX_MARGIN);
    localparam int unsigned CntW  = $clog2(BLINK_FRAMES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_FRAMES - 1);

    localparam logic [79:0] MsgStart = "START GAME";
    localparam logic [79:0] MsgOver  = "GAME OVER ";

    // 7 rows of 5 bits, row 0 in the top bits, bit 4 of each row = leftmost column.
    function automatic logic [34:0] glyph_rom(input logic [7:0] code);
        unique case (code)
            "S": glyph_rom = 35'b01111_10000_10000_01110_00001_00001_11110;
            "T": glyph_rom = 35'b11111_00100_00100_00100_00100_00100_00100;
            "A": glyph_rom = 35'b01110_10001_10001_11111_10001_10001_10001;
            "R": glyph_rom = 35'b11110_10001_10001_11110_10100_10010_10001;
            "G": glyph_rom = 35'b01110_10001_10000_10111_10001_10001_01111;
            "M": glyph_rom = 35'b10001_11011_10101_10101_10001_10001_10001;
            "E": glyph_rom = 35'b11111_10000_10000_11110_10000_10000_11111;
            "O": glyph_rom = 35'b01110_10001_10001_10001_10001_10001_01110;
            "V": glyph_rom = 35'b10001_10001_10001_10001_10001_01010_00100;
            default: glyph_rom = '0;
        endcase
    endfunction

    // Stage 1 registers
    logic [10:0] h1_q, h1_d, v1_q, v1_d;
    logic        hs1_q, hs1_d, vs1_q, vs1_d, hb1_q, hb1_d, vb1_q, vb1_d;
    logic        blank1_q, blank1_d, in_text1_q, in_text1_d, in_box1_q, in_box1_d;
    logic [10:0] char1_q, char1_d, col1_q, col1_d, row1_q, row1_d;
    // Stage 2 (output) next-state
    logic [10:0] hcount_d, vcount_d;
    logic        hsync_d, vsync_d, hblnk_d, vblnk_d;
    logic [11:0] rgb_d;
    // Frame state
    logic            vsync_q, msg_q, msg_d, visible_q, visible_d, frame_start;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [10:0] dx, dy, cell_x;
    logic [7:0]  code;
    logic [34:0] glyph;
    logic [4:0]  grow;
    logic        gbit;

    always_comb begin
        dx     = vga_in_hcount - TxLo;
        dy     = vga_in_vcount - TyLo;
        cell_x = dx >> SCALE_LOG2;

        h1_d       = vga_in_hcount;
        v1_d       = vga_in_vcount;
        hs1_d      = vga_in_hsync;
        vs1_d      = vga_in_vsync;
        hb1_d      = vga_in_hblnk;
        vb1_d      = vga_in_vblnk;
        blank1_d   = vga_in_vblnk || vga_in_hblnk;
        in_text1_d = (vga_in_hcount >= TxLo) && (vga_in_hcount < TxHi) &&
                     (vga_in_vcount >= TyLo) && (vga_in_vcount < TyHi);
        in_box1_d  = (vga_in_hcount >= BxLo) && (vga_in_hcount < BxHi) &&
                     (vga_in_vcount >= ByLo) && (vga_in_vcount < ByHi);
        // Constant divisor: synthesises to fixed logic, not a general divider.
        char1_d    = cell_x / 11'd6;
        col1_d     = cell_x % 11'd6;
        row1_d     = dy >> SCALE_LOG2;
    end

    always_comb begin
        frame_start = vga_in_vsync && !vsync_q;
        msg_d       = frame_start ? msg_sel : msg_q;
        cnt_d       = cnt_q;
        visible_d   = visible_q;
        if (!blink_en) begin
            cnt_d     = '0;
            visible_d = 1'b1;
        end else if (frame_start) begin
            if (cnt_q == CntLast) begin
                cnt_d     = '0;
                visible_d = ~visible_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        code = " ";
        for (int i = 0; i < 10; i++) begin
            if (char1_q == 11'(i)) begin
                code = msg_q ? MsgOver[8*(9-i) +: 8] : MsgStart[8*(9-i) +: 8];
            end
        end
        glyph = glyph_rom(code);
        // Rows 7+ and columns 5+ match nothing and stay off: the cell spacing.
        grow = '0;
        for (int r = 0; r < 7; r++) begin
            if (row1_q == 11'(r)) grow = glyph[5*(6-r) +: 5];
        end
        gbit = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (col1_q == 11'(c)) gbit = grow[4-c];
        end

        hcount_d = h1_q;
        vcount_d = v1_q;
        hsync_d  = hs1_q;
        vsync_d  = vs1_q;
        hblnk_d  = hb1_q;
        vblnk_d  = vb1_q;
        if (blank1_q)                             rgb_d = 12'h0_0_0;
        else if (in_text1_q && visible_q && gbit) rgb_d = TEXT_COLOR;
        else if (in_box1_q)                       rgb_d = BOX_COLOR;
        else                                      rgb_d = BG_COLOR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1_q <= '0; v1_q <= '0; hs1_q <= 1'b0; vs1_q <= 1'b0; hb1_q <= 1'b0; vb1_q <= 1'b0;
            blank1_q <= 1'b0; in_text1_q <= 1'b0; in_box1_q <= 1'b0;
            char1_q <= '0; col1_q <= '0; row1_q <= '0;
            vga_out_hcount <= '0; vga_out_vcount <= '0;
            vga_out_hsync <= 1'b0; vga_out_vsync <= 1'b0;
            vga_out_hblnk <= 1'b0; vga_out_vblnk <= 1'b0;
            vga_out_rgb <= '0;
            vsync_q <= 1'b0; msg_q <= 1'b0; visible_q <= 1'b1; cnt_q <= '0;
        end else begin
            h1_q <= h1_d; v1_q <= v1_d; hs1_q <= hs1_d; vs1_q <= vs1_d;
            hb1_q <= hb1_d; vb1_q <= vb1_d;
            blank1_q <= blank1_d; in_text1_q <= in_text1_d; in_box1_q <= in_box1_d;
            char1_q <= char1_d; col1_q <= col1_d; row1_q <= row1_d;
            vga_out_hcount <= hcount_d; vga_out_vcount <= vcount_d;
            vga_out_hsync <= hsync_d; vga_out_vsync <= vsync_d;
            vga_out_hblnk <= hblnk_d; vga_out_vblnk <= vblnk_d;
            vga_out_rgb <= rgb_d;
            vsync_q <= vga_in_vsync; msg_q <= msg_d; visible_q <= visible_d; cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_text_screen.sv
module tb_text_screen;
    logic        clk = 1'b0;
    logic        rst, msg_sel, blink_en;
    logic [10:0] in_h, in_v, out_h, out_v;
    logic        in_hs, in_vs, in_hb, in_vb, out_hs, out_vs, out_hb, out_vb;
    logic [11:0] in_rgb, out_rgb;

    int checks = 0;
    int errors = 0;
    // Reference state, updated only at events the bench itself creates.
    int msg_m = 0, vis_m = 1, cnt_m = 0;
    localparam int BlinkFrames = 2;

    always #5 clk = ~clk;

    text_screen #(.BLINK_FRAMES(BlinkFrames)) dut (
        .clk(clk), .rst(rst), .msg_sel(msg_sel), .blink_en(blink_en),
        .vga_in_hcount(in_h), .vga_in_vcount(in_v), .vga_in_hsync(in_hs),
        .vga_in_vsync(in_vs), .vga_in_hblnk(in_hb), .vga_in_vblnk(in_vb), .vga_in_rgb(in_rgb),
        .vga_out_hcount(out_h), .vga_out_vcount(out_v), .vga_out_hsync(out_hs),
        .vga_out_vsync(out_vs), .vga_out_hblnk(out_hb), .vga_out_vblnk(out_vb),
        .vga_out_rgb(out_rgb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Glyph art: '#' = lit, 7 rows of 5 chars.
    function automatic string font(input byte c);
        case (c)
            "S": return {".####", "#....", "#....", ".###.", "....#", "....#", "####."};
            "T": return {"#####", "..#..", "..#..", "..#..", "..#..", "..#..", "..#.."};
            "A": return {".###.", "#...#", "#...#", "#####", "#...#", "#...#", "#...#"};
            "R": return {"####.", "#...#", "#...#", "####.", "#.#..", "#..#.", "#...#"};
            "G": return {".###.", "#...#", "#....", "#.###", "#...#", "#...#", ".####"};
            "M": return {"#...#", "##.##", "#.#.#", "#.#.#", "#...#", "#...#", "#...#"};
            "E": return {"#####", "#....", "#....", "####.", "#....", "#....", "#####"};
            "O": return {".###.", "#...#", "#...#", "#...#", "#...#", "#...#", ".###."};
            "V": return {"#...#", "#...#", "#...#", "#...#", "#...#", ".#.#.", "..#.."};
            default: return {".....", ".....", ".....", ".....", ".....", ".....", "....."};
        endcase
    endfunction

    function automatic logic [11:0] model(input int h, input int v, input int m, input int vis,
                                          input bit blank);
        string msgs[2] = '{"START GAME", "GAME OVER "};
        int sc = 4;
        int cx, ci, col, row;
        string g;
        if (blank) return 12'h000;
        if (h >= 275 && h < 275 + 10 * 6 * sc && v >= 333 && v < 333 + 8 * sc) begin
            cx  = (h - 275) / sc;
            ci  = cx / 6;
            col = cx % 6;
            row = (v - 333) / sc;
            g   = font(msgs[m][ci]);
            if (vis != 0 && col < 5 && row < 7 && g[row * 5 + col] == "#") return 12'h000;
        end
        if (h >= 259 && h < 531 && v >= 317 && v < 381) return 12'hff0;
        return 12'h0f0;
    endfunction

    task automatic drive(input int h, input int v, input bit hs, input bit vs, input bit hb,
                         input bit vb);
        in_h = 11'(h); in_v = 11'(v); in_hs = hs; in_vs = vs; in_hb = hb; in_vb = vb;
        in_rgb = 12'($urandom);
    endtask

    // Drive one pixel held for 2 clk, then check the output colour.
    task automatic pix(input string tag, input int h, input int v, input bit hb);
        @(negedge clk);
        drive(h, v, 1'b0, 1'b0, hb, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check(tag, 32'(out_rgb), 32'(model(h, v, msg_m, vis_m, hb)));
    endtask

    task automatic vsync_edge();
        @(negedge clk);
        drive(0, 500, 1'b0, 1'b1, 1'b1, 1'b1);
        if (blink_en) begin
            if (cnt_m == BlinkFrames - 1) begin
                cnt_m = 0;
                vis_m = 1 - vis_m;
            end else begin
                cnt_m++;
            end
        end
        msg_m = int'(msg_sel);
        repeat (2) @(negedge clk);
        drive(0, 500, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    // Back-to-back random pixels, one per clock, scored 2 clk later.
    task automatic stream(input int n, input string tag);
        logic [31:0] q_rgb[$];
        logic [31:0] q_h[$];
        int h, v;
        bit hb;
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                check({tag, "_rgb"}, 32'(out_rgb), q_rgb.pop_front());
                check({tag, "_h"}, 32'(out_h), q_h.pop_front());
            end
            if (k < n) begin
                h  = int'($urandom_range(540, 250));
                v  = int'($urandom_range(390, 310));
                hb = ($urandom_range(7, 0) == 0);
                drive(h, v, 1'(h[0]), 1'b0, hb, 1'b0);
                q_rgb.push_back(32'(model(h, v, msg_m, vis_m, hb)));
                q_h.push_back(32'(h));
            end
        end
    endtask

    initial begin
        rst = 1'b1; msg_sel = 1'b1; blink_en = 1'b0;
        drive(123, 45, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_h", 32'(out_h), 32'd0);
        check("rst_v", 32'(out_v), 32'd0);
        check("rst_hs", 32'(out_hs), 32'd0);
        check("rst_hb", 32'(out_hb), 32'd0);
        check("rst_vb", 32'(out_vb), 32'd0);
        check("rst_rgb", 32'(out_rgb), 32'd0);

        // Release with msg_sel=1: START GAME until the first vsync rise.
        rst = 1'b0;
        drive(100, 50, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("lat1_h", 32'(out_h), 32'd0);
        @(negedge clk);
        check("lat2_h", 32'(out_h), 32'd100);
        check("lat2_v", 32'(out_v), 32'd50);
        check("lat2_hs", 32'(out_hs), 32'd1);
        check("lat2_rgb", 32'(out_rgb), 32'h0f0);

        pix("s_col0", 275, 333, 1'b0);
        pix("s_col1", 279, 333, 1'b0);
        pix("s_col4_start", 291, 333, 1'b0);
        pix("spacing", 299, 333, 1'b0);
        pix("box", 265, 333, 1'b0);
        pix("bg", 258, 333, 1'b0);
        pix("hblank", 279, 333, 1'b1);
        pix("box_edge_r", 530, 380, 1'b0);
        pix("box_out_r", 531, 380, 1'b0);
        stream(150, "rand_start");

        // msg_sel is already 1 but no frame start yet; the next edge commits it.
        vsync_edge();
        pix("g_col1", 279, 333, 1'b0);
        pix("g_col0", 275, 333, 1'b0);
        pix("g_col4", 291, 333, 1'b0);
        stream(150, "rand_over");

        // Mid-frame switch back must not tear.
        msg_sel = 1'b0;
        pix("midframe", 291, 333, 1'b0);
        vsync_edge();
        pix("after_switch", 291, 333, 1'b0);

        // Mid-frame async reset with msg_sel=1.
        msg_sel = 1'b1;
        vsync_edge();
        pix("pre_rst", 291, 333, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_rgb", 32'(out_rgb), 32'd0);
        check("async_h", 32'(out_h), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        msg_m = 0; vis_m = 1; cnt_m = 0;
        pix("post_rst_start", 291, 333, 1'b0);
        vsync_edge();
        pix("post_rst_over", 291, 333, 1'b0);

        // Blinking with a 2-frame phase.
        blink_en = 1'b1;
        msg_sel = 1'b0;
        vsync_edge();
        pix("blink_e1", 279, 333, 1'b0);
        vsync_edge();
        pix("blink_hidden", 279, 333, 1'b0);
        stream(80, "rand_hidden");
        vsync_edge();
        vsync_edge();
        pix("blink_shown", 279, 333, 1'b0);
        vsync_edge();
        vsync_edge();
        pix("blink_hidden2", 279, 333, 1'b0);
        blink_en = 1'b0;
        cnt_m = 0; vis_m = 1;
        pix("blink_off", 279, 333, 1'b0);
        vsync_edge();
        vsync_edge();
        pix("blink_off_stay", 279, 333, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
